serial_add_ctrl: RTL and testbench

Bit-serial N-bit adder controller that sequences the existing 1-bit `fulladder` over WIDTH clock cycles, one bit per cycle, LSB first. Accepts an operand pair on a valid/ready request port, shifts operands through the single shared full adder while holding the carry in a register, and presents sum, carry-out and signed overflow on a valid/ready response port. Sits between a requesting datapath and the one-bit adder resource, trading latency for area.

---
 rtl/serial_add_ctrl_pkg.sv | 11 +
 rtl/serial_add_ctrl_fulladder.sv | 11 +
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
// The SERIAL_ADD_SUB_EN build option is consumed by serial_add_ctrl, not here.
package serial_add_ctrl_pkg;
  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;
endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// One-bit full adder; the only arithmetic resource the serial controller sequences.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic y,
  output logic cout
);
  assign y    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one fulladder evaluated LSB first over WIDTH RUN cycles.
// Optional SERIAL_ADD_SUB_EN adds a req_sub port (A-B via inverted B and carry-in 1).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             req_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_e        state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_y, fa_cout;
  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: A + ~B + 1, caller's carry-in is dropped.
  assign b_ld   = req_sub ? ~req_b : req_b;
  assign cin_ld = req_sub | req_cin & ~req_sub;
`else
  assign b_ld   = req_b;
  assign cin_ld = req_cin;
`endif

  fulladder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .y    (fa_y),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid)   state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (rsp_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_sh  <= req_a;
          b_sh  <= b_ld;
          carry <= cin_ld;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {fa_y, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          // Final bit: carry still holds the carry into the MSB here.
          if (cnt == LAST) begin
            rsp_cout <= fa_cout;
            rsp_ovf  <= carry ^ fa_cout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_sum = sum_sh;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_cin, req_sub;
  logic [W-1:0] req_a, req_b, rsp_sum;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_ovf, busy;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef SERIAL_ADD_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from accept to response handshake; dly = cycles rsp_ready stays low in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int dly, input logic hold,
                        input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W-1:0] bb, es;
    logic [W:0]   tot;
    logic         c, eovf;
    int           n;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    tot  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    es   = tot[W-1:0];
    eovf = (a[W-1] == bb[W-1]) && (es[W-1] != a[W-1]);

    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    rsp_ready = (dly == 0);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = W'($urandom); req_b = W'($urandom); req_cin = 1'($urandom); req_sub = 1'($urandom);
    chk("busy_run", {31'b0, busy}, 1);
    chk("req_ready_run", {31'b0, req_ready}, 0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, W);
    chk("sum", {24'b0, rsp_sum}, {24'b0, es});
    chk("cout", {31'b0, rsp_cout}, {31'b0, tot[W]});
    chk("ovf", {31'b0, rsp_ovf}, {31'b0, eovf});
    for (int i = 0; i < dly; i++) begin
      if (hold) begin
        req_valid = 1'b1; req_a = na; req_b = nb; req_cin = 1'b0; req_sub = 1'b0;
      end
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_sum", {24'b0, rsp_sum}, {24'b0, es});
      chk("hold_flags", {30'b0, rsp_cout, rsp_ovf}, {30'b0, tot[W], eovf});
      chk("hold_req_ready", {31'b0, req_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rel_valid", {31'b0, rsp_valid}, 0);
    chk("rel_busy", {31'b0, busy}, 0);
    chk("rel_req_ready", {31'b0, req_ready}, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
    req_sub = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_sum", {24'b0, rsp_sum}, 0);
    chk("rst_flags", {30'b0, rsp_cout, rsp_ovf}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, req_ready}, 1);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1, 1'b0, 8'h00, 8'h00);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 2, 1'b0, 8'h00, 8'h00);
    // Response stalled 5 cycles while a new request waits; it must be taken only after release.
    run_op(8'h3C, 8'h45, 1'b1, 1'b0, 5, 1'b1, 8'h11, 8'h22);
    run_op(8'h11, 8'h22, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);

    // Abort mid-RUN.
    req_a = 8'hAA; req_b = 8'h55; req_cin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_valid", {31'b0, rsp_valid}, 0);
    chk("abort_ready", {31'b0, req_ready}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'h02, 8'h03, 1'b0, 1'b0, 1, 1'b0, 8'h00, 8'h00);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, 8'h00, 8'h00);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00);
`endif

    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00);
`else
      run_op(ra, rb, 1'($urandom), 1'b0, int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
